// File: rtl/display_pkg.sv
// Shared display constants: blank pattern, hex-to-segment table, scan FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
package display_pkg;

   // All segments dark on an active-low bus
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low gfedcba patterns, entry i is the glyph for hex digit i
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern (gfedcba).
// Latency: combinational, zero cycles.
// Backpressure: none.
module seg7_decode
   import display_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes NUM_DIGITS hex digits onto one active-low 7-seg bus with anti-ghost blanking and blink.
// Latency: all outputs registered; new digit appears one clk after the scan tick (one blank clk in between).
// Backpressure: none; every scan rising edge is consumed, digit inputs are snapshotted on the tick.
module seg7_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    scan_lvl,
   input  logic                    blink_lvl,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    scan_tick
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic                  scan_q;
   logic                  blink_q;
   logic                  tick;
   logic [IW-1:0]         idx_q, idx_d;
   logic [3:0]            cur_val_q, cur_val_d;
   logic                  cur_dp_q, cur_dp_d;
   logic                  cur_blank_q, cur_blank_d;
   logic                  armed_q, armed_d;
   state_e                state_q, state_d;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic                  dp_d;
   logic [6:0]            dec_seg;
   logic [NUM_DIGITS-1:0] sel_onehot;
   logic                  show;

   // Falling edges of the scan toggle are deliberately ignored
   assign tick = scan_lvl & ~scan_q;

   seg7_decode u_decode (
      .val_i (cur_val_q),
      .seg_o (dec_seg)
   );

   // Edge-detect and blink level sampling
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q  <= 1'b0;
         blink_q <= 1'b0;
      end else begin
         scan_q  <= scan_lvl;
         blink_q <= blink_lvl;
      end
   end

   // Digit index advance and snapshot of the newly selected digit on each tick
   always_comb begin
      idx_d       = idx_q;
      cur_val_d   = cur_val_q;
      cur_dp_d    = cur_dp_q;
      cur_blank_d = cur_blank_q;
      // Stays low after reset until the first tick so no stale digit is shown
      armed_d     = armed_q | tick;
      if (tick) begin
         idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
         cur_val_d   = digits_in[4*int'(idx_d) +: 4];
         cur_dp_d    = dp_in[idx_d];
         cur_blank_d = blank_in[idx_d];
      end
   end

   // Index and snapshot registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q       <= '0;
         cur_val_q   <= '0;
         cur_dp_q    <= 1'b0;
         cur_blank_q <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         cur_val_q   <= cur_val_d;
         cur_dp_q    <= cur_dp_d;
         cur_blank_q <= cur_blank_d;
         armed_q     <= armed_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_BLANK;
      else     state_q <= state_d;
   end

   // FSM next state: blank lasts one cycle, any tick while driving re-enters blank
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BLANK: state_d = S_DRIVE;
         S_DRIVE: if (tick) state_d = S_BLANK;
         default: state_d = S_BLANK;
      endcase
   end

   // FSM outputs, computed for the state being entered so the pins register alongside it.
   // A tick always darkens the bus for this edge: the snapshot it takes only lands in
   // cur_* at this same edge, so the first driven cycle is the one after.
   always_comb begin
      sel_onehot        = '0;
      sel_onehot[idx_q] = 1'b1;
      show = (state_d == S_DRIVE) && !tick && armed_q && !cur_blank_q
             && !(blink_q && blink_mask[idx_q]);
      an_d  = '1;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if (show) begin
         an_d  = ~sel_onehot;
         seg_d = dec_seg;
         dp_d  = ~cur_dp_q;
      end
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         an        <= '1;
         seg       <= SEG_BLANK;
         dp        <= 1'b1;
         scan_tick <= 1'b0;
      end else begin
         an        <= an_d;
         seg       <= seg_d;
         dp        <= dp_d;
         scan_tick <= tick;
      end
   end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: vector table, hand sequences, random run vs. reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan_mux;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, scan_lvl, blink_lvl;
   logic [15:0] digits_in;
   logic [3:0]  dp_in, blank_in, blink_mask;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp, scan_tick;

   logic [11:0] digits3;
   logic [2:0]  an3;
   logic [6:0]  seg3;
   logic        dp3, tick3;

   seg7_scan_mux #(.NUM_DIGITS(4)) u_dut (
      .clk(clk), .rst(rst), .scan_lvl(scan_lvl), .blink_lvl(blink_lvl),
      .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in), .blink_mask(blink_mask),
      .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick)
   );

   seg7_scan_mux #(.NUM_DIGITS(3)) u_dut3 (
      .clk(clk), .rst(rst), .scan_lvl(scan_lvl), .blink_lvl(blink_lvl),
      .digits_in(digits3), .dp_in(3'b000), .blank_in(3'b000), .blink_mask(3'b000),
      .an(an3), .seg(seg3), .dp(dp3), .scan_tick(tick3)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [6:0] seg_tab [16];

   // Reference model: state of the display as the spec describes it, in plain terms
   int         m_idx;
   logic [3:0] m_val;
   logic       m_dp, m_blank, m_live, m_scan, m_blink;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic       e_dp, e_tick;

   task automatic model_edge();
      logic t;
      t = scan_lvl & ~m_scan;
      if (rst) begin
         m_idx = 0; m_val = 4'h0; m_dp = 1'b0; m_blank = 1'b0; m_live = 1'b0;
         m_scan = 1'b0; m_blink = 1'b0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_tick = 1'b0;
      end else begin
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
         e_tick = t;
         if (t) begin
            m_idx   = (m_idx + 1) % 4;
            m_val   = 4'((digits_in >> (4 * m_idx)) & 16'hF);
            m_dp    = dp_in[m_idx];
            m_blank = blank_in[m_idx];
            m_live  = 1'b1;
         end else if (m_live && !m_blank && !(m_blink && blink_mask[m_idx])) begin
            e_an  = ~(4'b0001 << m_idx);
            e_seg = seg_tab[m_val];
            e_dp  = ~m_dp;
         end
         m_scan  = scan_lvl;
         m_blink = blink_lvl;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk_out(input string name, input logic [3:0] xa, input logic [6:0] xs,
                          input logic xd, input logic xt);
      chk({name, "_an"}, an, xa);
      chk({name, "_seg"}, seg, xs);
      chk({name, "_dp"}, dp, xd);
      chk({name, "_tick"}, scan_tick, xt);
   endtask

   task automatic do_reset();
      rst = 1'b1; scan_lvl = 1'b0; blink_lvl = 1'b0;
      dp_in = 4'h0; blank_in = 4'h0; blink_mask = 4'h0;
      repeat (3) cycle();
      chk_out("reset", 4'hF, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
   endtask

   // Rising edge then release; returns one cycle after the tick
   task automatic scan_edge();
      scan_lvl = 1'b1;
      cycle();
      chk("edge_tick", scan_tick, 1);
      chk("edge_blank_an", an, 4'hF);
      scan_lvl = 1'b0;
      cycle();
   endtask

   typedef struct {
      logic       scan;
      logic [3:0] an;
      logic [6:0] seg;
      logic       tick;
      logic [2:0] an3;
      logic [6:0] seg3;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      // scan, an, seg, tick, an3, seg3  (digits 16'h4321, 3-digit instance 12'h210)
      tbl[0]  = '{1'b1, 4'hF, 7'h7F, 1'b1, 3'h7, 7'h7F};
      tbl[1]  = '{1'b1, 4'hD, 7'h24, 1'b0, 3'h5, 7'h79};
      tbl[2]  = '{1'b0, 4'hD, 7'h24, 1'b0, 3'h5, 7'h79};
      tbl[3]  = '{1'b1, 4'hF, 7'h7F, 1'b1, 3'h7, 7'h7F};
      tbl[4]  = '{1'b1, 4'hB, 7'h30, 1'b0, 3'h3, 7'h24};
      tbl[5]  = '{1'b0, 4'hB, 7'h30, 1'b0, 3'h3, 7'h24};
      tbl[6]  = '{1'b1, 4'hF, 7'h7F, 1'b1, 3'h7, 7'h7F};
      tbl[7]  = '{1'b1, 4'h7, 7'h19, 1'b0, 3'h6, 7'h40};
      tbl[8]  = '{1'b0, 4'h7, 7'h19, 1'b0, 3'h6, 7'h40};
      tbl[9]  = '{1'b1, 4'hF, 7'h7F, 1'b1, 3'h7, 7'h7F};
      tbl[10] = '{1'b1, 4'hE, 7'h79, 1'b0, 3'h5, 7'h79};
      tbl[11] = '{1'b0, 4'hE, 7'h79, 1'b0, 3'h5, 7'h79};
      tbl[12] = '{1'b1, 4'hF, 7'h7F, 1'b1, 3'h7, 7'h7F};
      tbl[13] = '{1'b1, 4'hD, 7'h24, 1'b0, 3'h3, 7'h24};

      digits_in = 16'h4321;
      digits3   = 12'h210;

      // Reset, then idle with no scan edge
      do_reset();
      for (int i = 0; i < 20; i++) begin
         cycle();
         chk_out("idle", 4'hF, 7'h7F, 1'b1, 1'b0);
      end

      // Scan order table, both instances
      for (int i = 0; i < 14; i++) begin
         scan_lvl = tbl[i].scan;
         cycle();
         chk_out($sformatf("tbl%0d", i), tbl[i].an, tbl[i].seg, 1'b1, tbl[i].tick);
         chk($sformatf("tbl%0d_an3", i), an3, tbl[i].an3);
         chk($sformatf("tbl%0d_seg3", i), seg3, tbl[i].seg3);
      end

      // Snapshot: digit inputs changing between ticks leave the shown digit alone
      digits_in = 16'h0000;
      do_reset();
      repeat (4) scan_edge();
      cycle();
      cycle();
      chk_out("snap_before", 4'hE, 7'h40, 1'b1, 1'b0);
      digits_in = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk_out("snap_hold", 4'hE, 7'h40, 1'b1, 1'b0);
      end
      scan_edge();
      chk_out("snap_next", 4'hD, 7'h0E, 1'b1, 1'b0);

      // Blink on digit 0, then blank on digit 2 and decimal point on digit 1
      digits_in  = 16'h4321;
      do_reset();
      blink_mask = 4'b0001;
      repeat (4) scan_edge();
      chk_out("blink_pre", 4'hE, 7'h79, 1'b1, 1'b0);
      blink_lvl = 1'b1;
      cycle();
      chk_out("blink_lag", 4'hE, 7'h79, 1'b1, 1'b0);
      cycle();
      chk_out("blink_off", 4'hF, 7'h7F, 1'b1, 1'b0);
      blink_lvl = 1'b0;
      cycle();
      chk_out("blink_off_lag", 4'hF, 7'h7F, 1'b1, 1'b0);
      cycle();
      chk_out("blink_restore", 4'hE, 7'h79, 1'b1, 1'b0);
      blank_in = 4'b0100;
      dp_in    = 4'b0010;
      scan_edge();
      chk_out("dp_dig1", 4'hD, 7'h24, 1'b0, 1'b0);
      scan_edge();
      chk_out("blank_dig2", 4'hF, 7'h7F, 1'b1, 1'b0);
      scan_edge();
      chk_out("dig3_after", 4'h7, 7'h19, 1'b1, 1'b0);

      // Reset coinciding with a tick while driving digit 2, scan held high through release
      blank_in = 4'h0;
      dp_in    = 4'h0;
      do_reset();
      repeat (2) scan_edge();
      chk_out("pre_rst_drive", 4'hB, 7'h30, 1'b1, 1'b0);
      rst = 1'b1;
      scan_lvl = 1'b1;
      cycle();
      chk_out("rst_tick", 4'hF, 7'h7F, 1'b1, 1'b0);
      rst = 1'b0;
      cycle();
      chk_out("post_rst_tick", 4'hF, 7'h7F, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk_out("post_rst_hold", 4'hD, 7'h24, 1'b1, 1'b0);
      end

      // Randomised run against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)   scan_lvl   = ~scan_lvl;
         if ($urandom_range(0, 39) == 0)  blink_lvl  = ~blink_lvl;
         if ($urandom_range(0, 3) == 0)   digits_in  = 16'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            dp_in      = 4'($urandom);
            blank_in   = 4'($urandom) & 4'($urandom);
            blink_mask = 4'($urandom);
         end
         rst = ($urandom_range(0, 299) == 0);
         cycle();
         chk("rnd_an", an, e_an);
         chk("rnd_seg", seg, e_seg);
         chk("rnd_dp", dp, e_dp);
         chk("rnd_tick", scan_tick, e_tick);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
